// File: rtl/pll_reconfig_seq_if.sv
// Bus between the reconfiguration sequencer and an altpll_reconfig-style core.
//
// Handshake: rcfg_write and rcfg_reconfig are single-cycle strobes from the
// master. rcfg_type/rcfg_param/rcfg_data_in are valid in the rcfg_write cycle
// and hold afterwards. rcfg_busy high means the core is still working. The
// master waits at least 2 cycles after any strobe, then until rcfg_busy is low,
// before it issues the next strobe.
interface pll_reconfig_seq_if #(
    parameter int DATA_W = 9
);
    logic              rcfg_busy;
    logic [3:0]        rcfg_type;
    logic [2:0]        rcfg_param;
    logic [DATA_W-1:0] rcfg_data_in;
    logic              rcfg_write;
    logic              rcfg_reconfig;

    modport master (
        input  rcfg_busy,
        output rcfg_type, rcfg_param, rcfg_data_in, rcfg_write, rcfg_reconfig
    );

    modport slave (
        output rcfg_busy,
        input  rcfg_type, rcfg_param, rcfg_data_in, rcfg_write, rcfg_reconfig
    );
endinterface

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: latches N, M and C divide values on trigger,
// writes them as counter parameters into the reconfig core, fires reconfig and
// supervises lock with an areset retry loop.
module pll_reconfig_seq #(
    parameter int NUM_C        = 3,
    parameter int DATA_W       = 9,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int ARESET_CYC   = 16,
    parameter int MAX_RETRY    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 trigger,
    input  logic [7:0]           pll_m,
    input  logic [7:0]           pll_n,
    input  logic [8*NUM_C-1:0]   pll_c,
    input  logic [NUM_C-1:0]     c_en,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 stable,
    pll_reconfig_seq_if.master   rcfg,
    output logic                 pll_areset,
    input  logic                 locked,
    output logic [3:0]           dbg_state
);
    localparam int TMAX = (LOCK_TIMEOUT > ARESET_CYC) ? LOCK_TIMEOUT : ARESET_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(MAX_RETRY + 2);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WRITE, S_WWAIT, S_RECONF, S_RWAIT, S_LOCK, S_ARESET, S_ERR
    } state_t;

    state_t state_q, state_d;
    logic [7:0]         m_q, m_d, n_q, n_d;
    logic [8*NUM_C-1:0] c_q, c_d;
    logic [NUM_C-1:0]   cen_q, cen_d;
    // cidx: 0=N, 1=M, 2+k=Ck; sub: write index within the current counter
    logic [2:0]         cidx_q, cidx_d;
    logic [1:0]         sub_q, sub_d;
    logic               last_q, last_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic               error_q, error_d, done_q, done_d;
    logic [3:0]         type_q, type_d;
    logic [2:0]         param_q, param_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic [7:0]         cur_raw, cur_div, item_val;
    logic               bypass_only, nxt_found;
    logic [3:0]         item_type;
    logic [2:0]         item_param, nxt_idx;
    logic [NUM_C+1:0]   en_all;

    // Current write-list item from (cidx, sub) and the next enabled counter
    always_comb begin
        cur_raw = n_q;
        if (cidx_q == 3'd1) cur_raw = m_q;
        for (int k = 0; k < NUM_C; k++) begin
            if (cidx_q == 3'(k + 2)) cur_raw = c_q[8*k +: 8];
        end
        cur_div     = (cur_raw == 8'd0) ? 8'd1 : cur_raw;
        bypass_only = (cur_div == 8'd1);
        item_type   = (cidx_q < 3'd2) ? {1'b0, cidx_q} : ({1'b0, cidx_q} + 4'd2);
        item_param  = 3'd4;
        item_val    = 8'd0;
        if (bypass_only) begin
            item_val = 8'd1;
        end else begin
            case (sub_q)
                2'd1: begin item_param = 3'd0; item_val = 8'((9'(cur_div) + 9'd1) >> 1); end
                2'd2: begin item_param = 3'd1; item_val = cur_div >> 1; end
                2'd3: begin item_param = 3'd5; item_val = {7'd0, cur_div[0]}; end
                default: ;
            endcase
        end
        en_all    = {cen_q, 2'b11};
        nxt_found = 1'b0;
        nxt_idx   = cidx_q;
        for (int k = NUM_C + 1; k >= 0; k--) begin
            if (3'(k) > cidx_q && en_all[k]) begin
                nxt_found = 1'b1;
                nxt_idx   = 3'(k);
            end
        end
    end

    // Next-state and register-update logic of the sequencer
    always_comb begin
        state_d = state_q;
        m_d = m_q; n_d = n_q; c_d = c_q; cen_d = cen_q;
        cidx_d = cidx_q; sub_d = sub_q; last_d = last_q;
        timer_d = timer_q; retry_d = retry_q;
        error_d = error_q; done_d = 1'b0;
        type_d = type_q; param_d = param_q; data_d = data_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    m_d = pll_m; n_d = pll_n; c_d = pll_c; cen_d = c_en;
                    cidx_d = 3'd0; sub_d = 2'd0; last_d = 1'b0;
                    retry_d = '0; error_d = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_WRITE;
            S_WRITE: begin
                state_d = S_WWAIT;
                timer_d = '0;
                if (!bypass_only && sub_q != 2'd3) begin
                    sub_d = sub_q + 2'd1;
                end else if (nxt_found) begin
                    cidx_d = nxt_idx;
                    sub_d  = 2'd0;
                end else begin
                    last_d = 1'b1;
                end
            end
            S_WWAIT: begin
                timer_d = TW'(1);
                if (timer_q != '0 && !rcfg.rcfg_busy) state_d = last_q ? S_RECONF : S_WRITE;
            end
            S_RECONF: begin
                state_d = S_RWAIT;
                timer_d = '0;
            end
            S_RWAIT: begin
                timer_d = TW'(1);
                if (timer_q != '0 && !rcfg.rcfg_busy) begin
                    state_d = S_LOCK;
                    timer_d = '0;
                end
            end
            S_LOCK: begin
                if (locked) begin
                    done_d  = 1'b1;
                    retry_d = '0;
                    state_d = S_IDLE;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    timer_d = '0;
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_ARESET;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_ARESET: begin
                if (timer_q == TW'(ARESET_CYC - 1)) begin
                    timer_d = '0;
                    state_d = S_LOCK;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Bus fields change only when a write is about to be issued
        if (state_d == S_WRITE) begin
            type_d  = item_type;
            param_d = item_param;
            data_d  = DATA_W'(item_val);
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            m_q <= '0; n_q <= '0; c_q <= '0; cen_q <= '0;
            cidx_q <= '0; sub_q <= '0; last_q <= 1'b0;
            timer_q <= '0; retry_q <= '0;
            error_q <= 1'b0; done_q <= 1'b0;
            type_q <= '0; param_q <= '0; data_q <= '0;
        end else begin
            state_q <= state_d;
            m_q <= m_d; n_q <= n_d; c_q <= c_d; cen_q <= cen_d;
            cidx_q <= cidx_d; sub_q <= sub_d; last_q <= last_d;
            timer_q <= timer_d; retry_q <= retry_d;
            error_q <= error_d; done_q <= done_d;
            type_q <= type_d; param_q <= param_d; data_q <= data_d;
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        busy                = (state_q != S_IDLE) && (state_q != S_ERR);
        done                = done_q;
        error               = error_q;
        stable              = locked && (state_q == S_IDLE);
        pll_areset          = (state_q == S_ARESET);
        rcfg.rcfg_write     = (state_q == S_WRITE);
        rcfg.rcfg_reconfig  = (state_q == S_RECONF);
        rcfg.rcfg_type      = type_q;
        rcfg.rcfg_param     = param_q;
        rcfg.rcfg_data_in   = data_q;
        dbg_state           = state_q;
    end
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Testbench for pll_reconfig_seq: table of sequence vectors plus hand-written
// timeout, reset-abort and retrigger sequences, with a write scoreboard.
module tb_pll_reconfig_seq;
    localparam int NUM_C        = 3;
    localparam int DATA_W       = 9;
    localparam int LOCK_TIMEOUT = 64;
    localparam int ARESET_CYC   = 16;
    localparam int MAX_RETRY    = 2;
    localparam int W            = 4 + 3 + DATA_W;

    typedef struct {
        logic [7:0]         n;
        logic [7:0]         m;
        logic [8*NUM_C-1:0] c;
        logic [NUM_C-1:0]   cen;
        int                 blen;
        int                 exp_writes;
    } vec_t;

    logic clk, reset, trigger, locked;
    logic [7:0] pll_m, pll_n;
    logic [8*NUM_C-1:0] pll_c;
    logic [NUM_C-1:0] c_en;
    logic busy, done, error, stable, pll_areset;
    logic [3:0] dbg_state;

    pll_reconfig_seq_if #(.DATA_W(DATA_W)) rif ();

    pll_reconfig_seq #(
        .NUM_C(NUM_C), .DATA_W(DATA_W), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .ARESET_CYC(ARESET_CYC), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clock(clk), .reset(reset), .trigger(trigger),
        .pll_m(pll_m), .pll_n(pll_n), .pll_c(pll_c), .c_en(c_en),
        .busy(busy), .done(done), .error(error), .stable(stable),
        .rcfg(rif.master), .pll_areset(pll_areset), .locked(locked),
        .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int wr_cnt, rc_cnt, done_cnt, ar_cnt, ar_run, bcnt, busy_len;

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int t, input int p, input int d);
        return {4'(t), 3'(p), DATA_W'(d)};
    endfunction

    task automatic push_counter(input int t, input logic [7:0] d);
        int dd;
        dd = (d == 8'd0) ? 1 : int'(d);
        if (dd == 1) begin
            exp_q.push_back(mk(t, 4, 1));
        end else begin
            exp_q.push_back(mk(t, 4, 0));
            exp_q.push_back(mk(t, 0, (dd + 1) / 2));
            exp_q.push_back(mk(t, 1, dd / 2));
            exp_q.push_back(mk(t, 5, dd % 2));
        end
    endtask

    task automatic push_model(input vec_t v);
        push_counter(0, v.n);
        push_counter(1, v.m);
        for (int k = 0; k < NUM_C; k++)
            if (v.cen[k]) push_counter(4 + k, v.c[8*k +: 8]);
    endtask

    // One cycle: sample outputs on the falling edge, score writes, model the core's busy
    task automatic tick();
        logic [W-1:0] got, want;
        @(negedge clk);
        if (rif.rcfg_write) begin
            wr_cnt++;
            got = {rif.rcfg_type, rif.rcfg_param, rif.rcfg_data_in};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write got=%0h expected=none", got);
            end else begin
                want = exp_q.pop_front();
                check("write_item", 32'(got), 32'(want));
            end
        end
        if (rif.rcfg_reconfig) rc_cnt++;
        if (done) done_cnt++;
        if (pll_areset) begin
            ar_run++;
        end else if (ar_run != 0) begin
            check("areset_width", ar_run, ARESET_CYC);
            ar_cnt++;
            ar_run = 0;
        end
        if (rif.rcfg_write || rif.rcfg_reconfig) bcnt = busy_len;
        rif.rcfg_busy = (bcnt != 0);
        if (bcnt != 0) bcnt--;
    endtask

    task automatic start_seq(input vec_t v);
        wr_cnt = 0; rc_cnt = 0; done_cnt = 0; ar_cnt = 0; ar_run = 0;
        busy_len = v.blen;
        locked = 1'b0;
        pll_n = v.n; pll_m = v.m; pll_c = v.c; c_en = v.cen;
        trigger = 1'b1;
        tick();
        check("busy_after_accept", busy, 1);
        trigger = 1'b0;
    endtask

    task automatic run_seq(input vec_t v, input bit scramble, input bit retrig);
        int lock_wait;
        start_seq(v);
        if (scramble) begin
            pll_n = 8'($urandom); pll_m = 8'($urandom);
            pll_c = 24'($urandom); c_en = 3'($urandom);
        end
        lock_wait = -1;
        for (int i = 0; i < 3000 && done_cnt == 0 && !error; i++) begin
            trigger = retrig && (i == 4 || i == 6);
            tick();
            if (rc_cnt != 0 && lock_wait < 0) lock_wait = v.blen + 3;
            if (lock_wait > 0) lock_wait--;
            else if (lock_wait == 0) locked = 1'b1;
        end
        trigger = 1'b0;
        check("seq_done_seen", done_cnt, 1);
        check("seq_write_count", wr_cnt, v.exp_writes);
        check("seq_queue_empty", exp_q.size(), 0);
        check("seq_reconfig_count", rc_cnt, 1);
        check("seq_areset_count", ar_cnt, 0);
        check("seq_error", error, 0);
        repeat (8) tick();
        check("idle_busy", busy, 0);
        check("idle_stable", stable, 1);
        check("done_single", done_cnt, 1);
        check("no_extra_writes", wr_cnt, v.exp_writes);
        exp_q.delete();
    endtask

    task automatic run_timeout(input bit lock2);
        vec_t v;
        int lock_wait;
        bit err_seen, busy_at_err;
        v = '{8'd1, 8'd1, '0, '0, 2, 2};
        push_model(v);
        start_seq(v);
        err_seen = 1'b0; busy_at_err = 1'b1; lock_wait = -1;
        for (int i = 0; i < 3000 && done_cnt == 0 && !err_seen; i++) begin
            tick();
            if (error) begin err_seen = 1'b1; busy_at_err = busy; end
            if (lock2 && ar_cnt == 1 && lock_wait < 0) lock_wait = 10;
            if (lock_wait > 0) lock_wait--;
            else if (lock_wait == 0) locked = 1'b1;
        end
        check("to_writes", wr_cnt, 2);
        check("to_reconfig", rc_cnt, 1);
        if (!lock2) begin
            check("to_areset_pulses", ar_cnt, 2);
            check("to_error_seen", err_seen, 1);
            check("to_busy_in_err", busy_at_err, 0);
            check("to_no_done", done_cnt, 0);
            tick();
            check("to_error_sticky", error, 1);
            check("to_busy_after", busy, 0);
            check("to_stable", stable, 0);
        end else begin
            check("l2_areset_pulses", ar_cnt, 1);
            check("l2_done", done_cnt, 1);
            check("l2_no_error", err_seen, 0);
            tick();
            check("l2_error_clear", error, 0);
            check("l2_stable", stable, 1);
        end
        exp_q.delete();
    endtask

    vec_t vecs[5];
    vec_t v0;
    bit found;

    initial begin
        reset = 1'b1; trigger = 1'b0; locked = 1'b0;
        pll_m = '0; pll_n = '0; pll_c = '0; c_en = '0;
        rif.rcfg_busy = 1'b0;
        bcnt = 0; busy_len = 0;
        wr_cnt = 0; rc_cnt = 0; done_cnt = 0; ar_cnt = 0; ar_run = 0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_stable", stable, 0);
        check("rst_write", rif.rcfg_write, 0);
        check("rst_reconfig", rif.rcfg_reconfig, 0);
        check("rst_areset", pll_areset, 0);
        check("rst_bus", {rif.rcfg_type, rif.rcfg_param, rif.rcfg_data_in}, 0);
        reset = 1'b0;
        tick();

        // Reference sequence with literal expected writes
        v0 = '{8'd1, 8'd12, 24'h000005, 3'b001, 3, 9};
        exp_q.push_back(mk(0, 4, 1));
        exp_q.push_back(mk(1, 4, 0));
        exp_q.push_back(mk(1, 0, 6));
        exp_q.push_back(mk(1, 1, 6));
        exp_q.push_back(mk(1, 5, 0));
        exp_q.push_back(mk(4, 4, 0));
        exp_q.push_back(mk(4, 0, 3));
        exp_q.push_back(mk(4, 1, 2));
        exp_q.push_back(mk(4, 5, 1));
        run_seq(v0, 1'b0, 1'b0);

        // Table of sequences
        vecs[0] = '{8'd0,   8'd1,  24'h000000, 3'b000, 0, 2};
        vecs[1] = '{8'd2,   8'd3,  24'h010704, 3'b101, 2, 13};
        vecs[2] = '{8'd255, 8'd0,  24'h000600, 3'b010, 4, 9};
        vecs[3] = '{8'd1,   8'd1,  24'h030200, 3'b111, 1, 11};
        vecs[4] = '{8'd200, 8'd7,  24'h0900FF, 3'b101, 0, 16};
        vecs[4].blen = int'($urandom_range(0, 4));
        for (int i = 0; i < 5; i++) begin
            push_model(vecs[i]);
            run_seq(vecs[i], 1'b1, 1'b0);
        end

        // Trigger pulsed while busy
        push_model(vecs[1]);
        run_seq(vecs[1], 1'b0, 1'b1);

        // Lock never arrives, then lock arrives in the second window
        run_timeout(1'b0);
        run_timeout(1'b1);

        // Reset while waiting on the core, then a clean restart
        push_model(v0);
        start_seq(v0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (dbg_state == 4'd3 && wr_cnt == 3) found = 1'b1;
        end
        check("reached_wwait", found, 1);
        reset = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_error", error, 0);
        check("abort_strobes", {rif.rcfg_write, rif.rcfg_reconfig, pll_areset}, 0);
        check("abort_bus", {rif.rcfg_type, rif.rcfg_param, rif.rcfg_data_in}, 0);
        check("abort_state", dbg_state, 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (5) tick();
        check("abort_no_done", done_cnt, 0);
        push_model(v0);
        run_seq(v0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
